// File: rtl/cc_pkg.sv
// cc_pkg: shared definitions for the shifter next-state logic.
//   CC_WIDTH      default data width (opcode/shift semantics assume 8)
//   OP_*          3-bit opcode encodings; 101..111 are reserved (hold)
//   shift_mode_t  direction/fill select for the barrel shifter
package cc_pkg;

   localparam int CC_WIDTH = 8;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_LSL  = 3'b010;
   localparam logic [2:0] OP_LSR  = 3'b011;
   localparam logic [2:0] OP_ASR  = 3'b100;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10
   } shift_mode_t;

endpackage

// File: rtl/cc_if.sv
// cc_if: operand/result bundle of the shifter next-state logic.
//   op, shamt, d_in, d_out  operation request and current register value
//   d_next                  combinational next value
//   d_q                     registered copy of d_next
// Modports: master drives the request and reads results, slave is the logic.
interface cc_if
   import cc_pkg::*;
#(
   parameter int WIDTH = CC_WIDTH
);
   logic [2:0]       op;
   logic [1:0]       shamt;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] d_out;
   logic [WIDTH-1:0] d_next;
   logic [WIDTH-1:0] d_q;

   modport master (
      output op, shamt, d_in, d_out,
      input  d_next, d_q
   );

   modport slave (
      input  op, shamt, d_in, d_out,
      output d_next, d_q
   );
endinterface

// File: rtl/cc_shift_unit.sv
// cc_shift_unit: combinational 0..3 bit barrel shifter, two mux stages
// (shift by 1, then by 2). No rotate, no carry out.
//   data    operand
//   shamt   shift amount 0..3
//   mode    SH_LSL (zero fill LSB), SH_LSR (zero fill MSB),
//           SH_ASR (fill with data MSB)
//   result  shifted operand
module cc_shift_unit
   import cc_pkg::*;
#(
   parameter int WIDTH = CC_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       shamt,
   input  shift_mode_t      mode,
   output logic [WIDTH-1:0] result
);

   logic             shift_left;
   logic             fill_bit;
   logic [WIDTH-1:0] s1_left;
   logic [WIDTH-1:0] s1_right;
   logic [WIDTH-1:0] stage1;
   logic [WIDTH-1:0] s2_left;
   logic [WIDTH-1:0] s2_right;

   assign shift_left = (mode == SH_LSL);
   // Sign fill only for ASR; the sign bit is taken from the original operand,
   // which equals the stage-1 MSB under ASR, so both stages share it.
   assign fill_bit   = (mode == SH_ASR) ? data[WIDTH-1] : 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_stage1
         if (gi == 0) begin : g_l0
            assign s1_left[gi] = 1'b0;
         end else begin : g_l
            assign s1_left[gi] = data[gi-1];
         end
         if (gi == WIDTH-1) begin : g_rfill
            assign s1_right[gi] = fill_bit;
         end else begin : g_r
            assign s1_right[gi] = data[gi+1];
         end
      end

      for (gi = 0; gi < WIDTH; gi++) begin : g_stage2
         if (gi < 2) begin : g_l0
            assign s2_left[gi] = 1'b0;
         end else begin : g_l
            assign s2_left[gi] = stage1[gi-2];
         end
         if (gi > WIDTH-3) begin : g_rfill
            assign s2_right[gi] = fill_bit;
         end else begin : g_r
            assign s2_right[gi] = stage1[gi+2];
         end
      end
   endgenerate

   assign stage1 = shamt[0] ? (shift_left ? s1_left : s1_right) : data;
   assign result = shamt[1] ? (shift_left ? s2_left : s2_right) : stage1;

endmodule

// File: rtl/cc_logic.sv
// cc_logic: next-state logic of the 8-bit shifter register.
//   clk     rising-edge clock, used only by the d_q register
//   reset   synchronous active-high reset of d_q
//   bus     cc_if slave: op/shamt/d_in/d_out in, d_next/d_q out
// d_next is purely combinational (NOP/reserved hold d_out, LOAD takes d_in,
// LSL/LSR/ASR shift d_out by shamt). d_q is d_next delayed by one cycle.
module cc_logic
   import cc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   cc_if.slave  bus
);

   shift_mode_t         mode;
   logic [CC_WIDTH-1:0] shifted;
   logic [CC_WIDTH-1:0] d_next_comb;
   logic [CC_WIDTH-1:0] d_q_reg;

   // Non-shift opcodes pick LSL here; the result is discarded by the op mux.
   always_comb begin
      mode = SH_LSL;
      if (bus.op == OP_LSR) begin
         mode = SH_LSR;
      end else if (bus.op == OP_ASR) begin
         mode = SH_ASR;
      end
   end

   cc_shift_unit #(
      .WIDTH (CC_WIDTH)
   ) u_shift (
      .data   (bus.d_out),
      .shamt  (bus.shamt),
      .mode   (mode),
      .result (shifted)
   );

   // Reserved opcodes fall to the default and hold, so d_next is never X.
   always_comb begin
      d_next_comb = bus.d_out;
      case (bus.op)
         OP_LOAD: d_next_comb = bus.d_in;
         OP_LSL,
         OP_LSR,
         OP_ASR:  d_next_comb = shifted;
         default: d_next_comb = bus.d_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d_q_reg <= '0;
      end else begin
         d_q_reg <= d_next_comb;
      end
   end

   assign bus.d_next = d_next_comb;
   assign bus.d_q    = d_q_reg;

endmodule

// File: tb/tb_cc_logic.sv
// tb_cc_logic: scoreboard bench for cc_logic. Expected values are pushed
// when stimulus is driven and popped when the DUT output is sampled.
module tb_cc_logic;
   import cc_pkg::*;

   logic clk;
   logic reset;
   logic tie_dout;
   logic [7:0] d_out_tb;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   cc_if #(.WIDTH(8)) bus ();

   cc_logic dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Feedback path: d_out either driven by the bench or tied to d_q.
   assign bus.d_out = tie_dout ? bus.d_q : d_out_tb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, need done");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input logic [7:0] got);
      logic [7:0] e;
      string t;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 8'h01, 8'h00);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         $display("%s: op=%b shamt=%0d d_in=%h d_out=%h -> %h (exp %h)",
                  t, bus.op, bus.shamt, bus.d_in, bus.d_out, got, e);
         chk(t, got, e);
      end
   endtask

   // Combinational transaction: drive, push expectation, sample 1 ns later.
   task automatic comb_txn(input string tag, input logic [2:0] op, input logic [1:0] sh,
                           input logic [7:0] din, input logic [7:0] dout, input logic [7:0] exp);
      bus.op   = op;
      bus.shamt = sh;
      bus.d_in = din;
      d_out_tb = dout;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      #1;
      pop_chk(bus.d_next);
      chk({tag, "_known"}, {7'b0, $isunknown(bus.d_next)}, 8'h00);
      #9;
   endtask

   // Clocked transaction: drive on falling edge, check d_q after next rise.
   task automatic seq_txn(input string tag, input logic rst, input logic [2:0] op,
                          input logic [1:0] sh, input logic [7:0] din, input logic [7:0] exp);
      @(negedge clk);
      reset     = rst;
      bus.op    = op;
      bus.shamt = sh;
      bus.d_in  = din;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      pop_chk(bus.d_q);
   endtask

   initial begin
      reset     = 1'b1;
      tie_dout  = 1'b0;
      d_out_tb  = 8'h00;
      bus.op    = OP_NOP;
      bus.shamt = 2'd0;
      bus.d_in  = 8'h00;

      // Opcode walk, shamt=1
      comb_txn("nop",      OP_NOP,  2'd1, 8'hB5, 8'hC7, 8'hC7);
      comb_txn("load",     OP_LOAD, 2'd1, 8'hB5, 8'hC7, 8'hB5);
      comb_txn("lsl1",     OP_LSL,  2'd1, 8'hB5, 8'hC7, 8'h8E);
      comb_txn("lsr1",     OP_LSR,  2'd1, 8'hB5, 8'hC7, 8'h63);
      comb_txn("asr1",     OP_ASR,  2'd1, 8'hB5, 8'hC7, 8'hE3);
      // Other amounts and boundaries
      comb_txn("asr2",     OP_ASR,  2'd2, 8'hB5, 8'hC7, 8'hF1);
      comb_txn("lsl3",     OP_LSL,  2'd3, 8'hB5, 8'hC7, 8'h38);
      comb_txn("lsr3",     OP_LSR,  2'd3, 8'hB5, 8'hC7, 8'h18);
      comb_txn("lsl2",     OP_LSL,  2'd2, 8'hB5, 8'hC7, 8'h1C);
      comb_txn("lsl0",     OP_LSL,  2'd0, 8'hB5, 8'hC7, 8'hC7);
      comb_txn("lsr0",     OP_LSR,  2'd0, 8'hB5, 8'hC7, 8'hC7);
      comb_txn("asr0",     OP_ASR,  2'd0, 8'hB5, 8'hC7, 8'hC7);
      comb_txn("asr3_pos", OP_ASR,  2'd3, 8'hB5, 8'h7F, 8'h0F);
      comb_txn("asr3_neg", OP_ASR,  2'd3, 8'hB5, 8'h80, 8'hF0);
      comb_txn("lsr3_msb", OP_LSR,  2'd3, 8'hB5, 8'h80, 8'h10);
      comb_txn("load_sh3", OP_LOAD, 2'd3, 8'h3C, 8'h80, 8'h3C);
      // Reserved opcodes hold
      comb_txn("rsv101",   3'b101,  2'd2, 8'hFF, 8'h5A, 8'h5A);
      comb_txn("rsv110",   3'b110,  2'd1, 8'hFF, 8'h5A, 8'h5A);
      comb_txn("rsv111",   3'b111,  2'd3, 8'hFF, 8'h5A, 8'h5A);

      // Registered path, d_out tied to d_q
      tie_dout = 1'b1;
      seq_txn("rst1",   1'b1, OP_NOP,  2'd0, 8'h00, 8'h00);
      seq_txn("rst2",   1'b1, OP_LOAD, 2'd0, 8'hB5, 8'h00);
      seq_txn("q_load", 1'b0, OP_LOAD, 2'd1, 8'hB5, 8'hB5);
      seq_txn("q_lsl_a",1'b0, OP_LSL,  2'd1, 8'hB5, 8'h6A);
      seq_txn("q_lsl_b",1'b0, OP_LSL,  2'd1, 8'hB5, 8'hD4);
      seq_txn("q_lsl_c",1'b0, OP_LSL,  2'd1, 8'hB5, 8'hA8);

      // Reset mid-sequence: d_next still tracks inputs before the edge
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("dnext_in_reset", bus.d_next, 8'h50);
      $display("dnext_in_reset: d_q=%h d_next=%h", bus.d_q, bus.d_next);
      exp_q.push_back(8'h00);
      tag_q.push_back("q_midreset");
      @(posedge clk);
      #1;
      pop_chk(bus.d_q);
      chk("dnext_after_reset", bus.d_next, 8'h00);

      // Untied d_out while reset held: d_next still combinational
      tie_dout = 1'b0;
      d_out_tb = 8'hC7;
      bus.op   = OP_ASR;
      bus.shamt = 2'd1;
      #1;
      chk("dnext_reset_comb", bus.d_next, 8'hE3);
      $display("dnext_reset_comb: d_next=%h", bus.d_next);
      tie_dout = 1'b1;

      seq_txn("q_reload", 1'b0, OP_LOAD, 2'd0, 8'h3C, 8'h3C);
      seq_txn("q_asr2",   1'b0, OP_ASR,  2'd2, 8'h00, 8'h0F);
      seq_txn("q_nop",    1'b0, OP_NOP,  2'd2, 8'hAA, 8'h0F);

      if (exp_q.size() != 0) chk("scoreboard_drain", 8'h01, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cc_logic.md
Name: cc_logic

Overview:
- Next-state logic of the 8-bit shifter register: from an opcode and a 2-bit shift amount, computes the next register value from the current value (d_out) or the load data (d_in).
- d_next is purely combinational with zero latency and feeds the parent shifter's state register.
- Also holds a registered copy of d_next (d_q) on its single clock, so the block can run standalone and a bench can check it at cycle level.

Parameters:
- WIDTH, 8, data width; op/shamt semantics below assume 8.

Ports:
- clk  input  1  rising-edge clock; used only by the d_q register.
- reset  input  1  synchronous, active-high reset.
- op  input  3  operation select.
- shamt  input  2  shift amount, 0..3.
- d_in  input  8  parallel load data.
- d_out  input  8  current register value, fed back from the state register.
- d_next  output  8  combinational next value.
- d_q  output  8  registered d_next.

Behaviour:
- Opcodes, evaluated combinationally; X-free for all inputs:
  - 000 NOP: d_next = d_out.
  - 001 LOAD: d_next = d_in, shamt ignored.
  - 010 LSL: d_next = d_out << shamt, zero fill from LSB.
  - 011 LSR: d_next = d_out >> shamt, zero fill from MSB.
  - 100 ASR: d_next = d_out >>> shamt, fill with d_out[7].
  - 101, 110, 111 reserved: d_next = d_out (hold). Never X.
- shamt = 00 on any shift op: d_next = d_out.
- Maximum shift is 3; no wrap-around or rotate.
- No carry-out or flags are produced.
- d_next has no dependence on clk or reset. It responds within the same delta cycle as any input change.
- d_q register, on each rising clk:
  - reset = 1: d_q <= 8'h00.
  - otherwise: d_q <= d_next.
  - Latency d_next -> d_q is 1 cycle.
- Reset asserted mid-operation clears d_q on that edge. d_next is unaffected.
- d_q is 8'h00 from the first reset edge onward. It is undefined before the first reset edge.

Decomposition:
- Shared package cc_pkg:
  - opcode localparams: OP_NOP=3'b000, OP_LOAD=3'b001, OP_LSL=3'b010, OP_LSR=3'b011, OP_ASR=3'b100.
  - WIDTH default.
- One natural sub-module, cc_shift_unit:
  - Combinational barrel shifter with inputs data[7:0], shamt[1:0] and a 2-bit mode (lsl/lsr/asr).
  - Implemented as two mux stages (by 1, by 2).
  - cc_logic instantiates it and muxes its result with d_out and d_in by op.

Test Plan:
- d_in=8'hB5, d_out=8'hC7, shamt=01, op stepped 000,001,010,011,100 at 10 ns intervals -> d_next = C7, B5, 8E, 63, E3.
- d_out=8'hC7, op=ASR, shamt=10 -> F1; op=LSL, shamt=11 -> 38; op=LSR, shamt=11 -> 18; any shift op with shamt=00 -> C7.
- d_out=8'h7F, op=ASR, shamt=11 -> 0F (positive sign fill); d_out=8'h80, op=ASR, shamt=11 -> F0.
- op=101, 110, 111 with d_out=8'h5A, d_in=8'hFF -> d_next=5A, never X.
- reset=1 for 2 cycles -> d_q=00. Then release with op=LOAD, d_in=B5 -> d_q=B5 one edge later. Then op=LSL, shamt=01, d_out tied to d_q -> d_q=6A, then D4.
- Assert reset during a running shift sequence -> d_q=00 on that edge while d_next still tracks the inputs combinationally.
